// File: rtl/delay_counter_pkg.sv
// Shared constants for the delay counter bank: mode encodings and default sizing.
package delay_counter_pkg;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    localparam int unsigned     DEFAULT_WIDTH     = 48;
    localparam int unsigned     DEFAULT_NCH       = 4;
    localparam longint unsigned DEFAULT_THRESHOLD = 64'd4;

endpackage : delay_counter_pkg

// File: rtl/delay_counter_channel.sv
// One down-counting delay timer with one-shot/periodic mode, early-warning
// threshold flag and a single-cycle fire strobe.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   load       load strobe (level); reloads count and period every cycle held
//   l          load value
//   mode       mode captured with load (0 one-shot, 1 periodic)
//   pause      freeze counting (only with DELAY_COUNTER_PAUSE_EN)
//   expired    high while count == 0
//   threshold  high while count <= THRESHOLD
//   fired      one-cycle strobe when count reaches 0 by counting
//
// Optional macro: DELAY_COUNTER_PAUSE_EN adds the pause input.
module delay_counter_channel
    import delay_counter_pkg::*;
#(
    parameter int unsigned     WIDTH     = DEFAULT_WIDTH,
    parameter longint unsigned THRESHOLD = DEFAULT_THRESHOLD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] l,
    input  logic             mode,
`ifdef DELAY_COUNTER_PAUSE_EN
    input  logic             pause,
`endif
    output logic             expired,
    output logic             threshold,
    output logic             fired
);

    // Threshold must be representable at WIDTH bits.
    if ((WIDTH < 64) && (THRESHOLD >= (64'd1 << WIDTH))) begin : g_bad_threshold
        $error("delay_counter_channel: THRESHOLD does not fit in WIDTH bits");
    end

    localparam logic [WIDTH-1:0] THR = WIDTH'(THRESHOLD);

    logic [WIDTH-1:0] count, count_n;
    logic [WIDTH-1:0] period, period_n;
    logic             mode_q, mode_n;
    logic             fired_n;
    logic             run_c;

`ifdef DELAY_COUNTER_PAUSE_EN
    assign run_c = ~pause;
`else
    assign run_c = 1'b1;
`endif

    // Next-state: load beats everything but reset; counting stops at 0.
    always_comb begin
        count_n  = count;
        period_n = period;
        mode_n   = mode_q;
        fired_n  = 1'b0;
        if (load) begin
            count_n  = l;
            period_n = l;
            mode_n   = mode;
        end else if (run_c) begin
            if (count > WIDTH'(1)) begin
                count_n = count - WIDTH'(1);
            end else if (count == WIDTH'(1)) begin
                count_n = '0;
                fired_n = 1'b1;
            end else if (mode_q == MODE_PERIODIC) begin
                count_n = period;
            end
        end
    end

    // State register; flags are registered decodes of the next count so they
    // always equal a decode of the current count.
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            period    <= '0;
            mode_q    <= MODE_ONESHOT;
            fired     <= 1'b0;
            expired   <= 1'b1;
            threshold <= 1'b1;
        end else begin
            count     <= count_n;
            period    <= period_n;
            mode_q    <= mode_n;
            fired     <= fired_n;
            expired   <= (count_n == '0);
            threshold <= (count_n <= THR);
        end
    end

endmodule : delay_counter_channel

// File: rtl/delay_counter_bank.sv
// Bank of NCH independent delay timers used by the pulse sequencer.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   load       per-channel load strobe
//   l          per-channel load values, channel i at [i*WIDTH +: WIDTH]
//   mode       per-channel mode captured with load (0 one-shot, 1 periodic)
//   pause      global freeze (only with DELAY_COUNTER_PAUSE_EN)
//   expired    per-channel count == 0
//   threshold  per-channel count <= THRESHOLD
//   fired      per-channel one-cycle expiry strobe
//
// Optional macro: DELAY_COUNTER_PAUSE_EN adds the pause input.
module delay_counter_bank
    import delay_counter_pkg::*;
#(
    parameter int unsigned     WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned     NCH       = DEFAULT_NCH,
    parameter longint unsigned THRESHOLD = DEFAULT_THRESHOLD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       load,
    input  logic [NCH*WIDTH-1:0] l,
    input  logic [NCH-1:0]       mode,
`ifdef DELAY_COUNTER_PAUSE_EN
    input  logic                 pause,
`endif
    output logic [NCH-1:0]       expired,
    output logic [NCH-1:0]       threshold,
    output logic [NCH-1:0]       fired
);

    for (genvar i = 0; i < int'(NCH); i++) begin : g_ch
        delay_counter_channel #(
            .WIDTH     (WIDTH),
            .THRESHOLD (THRESHOLD)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .load      (load[i]),
            .l         (l[i*WIDTH +: WIDTH]),
            .mode      (mode[i]),
`ifdef DELAY_COUNTER_PAUSE_EN
            .pause     (pause),
`endif
            .expired   (expired[i]),
            .threshold (threshold[i]),
            .fired     (fired[i])
        );
    end

endmodule : delay_counter_bank

// File: tb/tb_delay_counter_bank.sv
// Directed self-checking bench for delay_counter_bank (default parameters).
module tb_delay_counter_bank;

    localparam int unsigned W = 48;
    localparam int unsigned N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   load;
    logic [N*W-1:0] l;
    logic [N-1:0]   mode;
    logic [N-1:0]   expired;
    logic [N-1:0]   threshold;
    logic [N-1:0]   fired;
`ifdef DELAY_COUNTER_PAUSE_EN
    logic           pause;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    delay_counter_bank #(
        .WIDTH     (W),
        .NCH       (N),
        .THRESHOLD (64'd4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .l         (l),
        .mode      (mode),
`ifdef DELAY_COUNTER_PAUSE_EN
        .pause     (pause),
`endif
        .expired   (expired),
        .threshold (threshold),
        .fired     (fired)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load(input int ch, input logic [W-1:0] v, input logic m);
        load[ch]       = 1'b1;
        l[ch*W +: W]   = v;
        mode[ch]       = m;
    endtask

    initial begin
        rst  = 1'b1;
        load = '0;
        l    = '0;
        mode = '0;
`ifdef DELAY_COUNTER_PAUSE_EN
        pause = 1'b0;
`endif

        // Reset state
        repeat (3) tick();
        check("rst_expired",   64'(expired),   64'hF);
        check("rst_threshold", 64'(threshold), 64'hF);
        check("rst_fired",     64'(fired),     64'h0);
        rst = 1'b0;

        // One-shot ch0, l=0x22: threshold at +30, expired/fired at +34
        set_load(0, 48'h22, 1'b0);
        tick();
        load = '0;
        check("os_load", 64'({threshold[0], expired[0], fired[0]}), 64'b000);
        for (int j = 1; j <= 35; j++) begin
            tick();
            check($sformatf("os_ch0 j=%0d", j),
                  64'({threshold[0], expired[0], fired[0]}),
                  64'({(j >= 30), (j >= 34), (j == 34)}));
        end

        // Periodic ch1 l=6 (period 7), periodic ch2 l=0 (never fires)
        set_load(1, 48'd6, 1'b1);
        set_load(2, 48'd0, 1'b1);
        tick();
        load = '0;
        check("per_load_ch1", 64'({threshold[1], expired[1], fired[1]}), 64'b000);
        check("per_load_ch2", 64'({expired[2], fired[2]}), 64'b10);
        for (int j = 1; j <= 35; j++) begin
            tick();
            check($sformatf("per_ch1 j=%0d", j),
                  64'({threshold[1], expired[1], fired[1]}),
                  64'({((j % 7) >= 2), ((j % 7) == 6), ((j % 7) == 6)}));
            check($sformatf("per_ch2 j=%0d", j), 64'({expired[2], fired[2]}), 64'b10);
            check($sformatf("os_hold_ch0 j=%0d", j), 64'({expired[0], fired[0]}), 64'b10);
        end

        // Reset mid-count abandons the count with no fired pulse
        set_load(0, 48'd2000, 1'b0);
        tick();
        load = '0;
        repeat (99) tick();
        check("long_ch0_running", 64'(expired[0]), 64'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_expired", 64'(expired), 64'hF);
        check("midrst_fired",   64'(fired),   64'h0);
        tick();
        check("postrst_fired",   64'(fired),   64'h0);
        check("postrst_expired", 64'(expired), 64'hF);

        // Load held 10 cycles keeps reloading; expiry 6 after last load edge
        set_load(0, 48'd6, 1'b0);
        for (int j = 0; j < 10; j++) begin
            tick();
            check($sformatf("hold_load j=%0d", j), 64'({expired[0], fired[0]}), 64'b00);
        end
        load = '0;
        for (int j = 1; j <= 6; j++) begin
            tick();
            check($sformatf("after_hold j=%0d", j),
                  64'({expired[0], fired[0]}), (j == 6) ? 64'b11 : 64'b00);
        end

        // ch1 expires on the same edge that ch0 and ch3 load
        set_load(1, 48'd3, 1'b0);
        tick();
        load = '0;
        tick();
        tick();
        set_load(0, 48'd5, 1'b0);
        set_load(3, 48'd5, 1'b0);
        tick();
        load = '0;
        check("simul_fired0",   64'(fired),   64'b0010);
        check("simul_expired0", 64'(expired), 64'b0110);
        for (int j = 1; j <= 5; j++) begin
            tick();
            check($sformatf("simul_fired j=%0d", j), 64'(fired),
                  (j == 5) ? 64'b1001 : 64'b0000);
            check($sformatf("simul_expired j=%0d", j), 64'(expired),
                  (j == 5) ? 64'b1111 : 64'b0110);
        end

        // Load on the count==1 cycle: reload wins, no fired pulse
        set_load(0, 48'd3, 1'b0);
        tick();
        load = '0;
        tick();
        tick();
        set_load(0, 48'd4, 1'b0);
        tick();
        load = '0;
        check("reload_at_one", 64'({expired[0], fired[0]}), 64'b00);
        for (int j = 1; j <= 4; j++) begin
            tick();
            check($sformatf("reload_run j=%0d", j),
                  64'({expired[0], fired[0]}), (j == 4) ? 64'b11 : 64'b00);
        end

`ifdef DELAY_COUNTER_PAUSE_EN
        // Pause 4 cycles mid-count delays expiry by exactly 4
        set_load(0, 48'd10, 1'b0);
        tick();
        load = '0;
        repeat (3) tick();
        pause = 1'b1;
        repeat (4) tick();
        pause = 1'b0;
        repeat (6) tick();
        check("pause_pre", 64'({expired[0], fired[0]}), 64'b00);
        tick();
        check("pause_exp", 64'({expired[0], fired[0]}), 64'b11);

        // Load during pause takes effect, count then frozen
        pause = 1'b1;
        set_load(0, 48'd2, 1'b0);
        tick();
        load = '0;
        check("pause_load", 64'({expired[0], fired[0]}), 64'b00);
        tick();
        check("pause_frozen", 64'({expired[0], fired[0]}), 64'b00);
        pause = 1'b0;
        tick();
        check("unpause_1", 64'({expired[0], fired[0]}), 64'b00);
        tick();
        check("unpause_2", 64'({expired[0], fired[0]}), 64'b11);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_delay_counter_bank
